// File: rtl/tdm_demux_one_to_four_pkg.sv
// Shared types and constants for the 1-to-4 TDM demultiplexer.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;

  localparam int NUM_CH = 4;

endpackage

// File: rtl/tdm_demux_one_to_four_if.sv
// Serial input stream and reassembled parallel channel outputs of the TDM demux.
interface tdm_demux_one_to_four_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] iData;
  logic             iValid;
  logic             iFrame;
  logic [WIDTH-1:0] oChA;
  logic [WIDTH-1:0] oChB;
  logic [WIDTH-1:0] oChC;
  logic [WIDTH-1:0] oChD;
  logic             oFrameValid;
  logic             oSyncErr;
  logic             oLocked;

  modport master (
    output iData, iValid, iFrame,
    input  oChA, oChB, oChC, oChD, oFrameValid, oSyncErr, oLocked
  );

  modport slave (
    input  iData, iValid, iFrame,
    output oChA, oChB, oChC, oChD, oFrameValid, oSyncErr, oLocked
  );
endinterface

// File: rtl/tdm_demux_one_to_four_slot_counter.sv
// Two-bit TDM slot counter; clear wins over load-to-1, which wins over increment.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iClr,
  input  logic       iLoad1,
  input  logic       iInc,
  output logic [1:0] oSlot,
  output logic       oLast
);

  logic [1:0] slot_d;
  logic [1:0] slot_q;

  always_comb begin
    slot_d = slot_q;
    if (iClr) begin
      slot_d = SLOT_A;
    end else if (iLoad1) begin
      slot_d = SLOT_B;
    end else if (iInc) begin
      slot_d = slot_q + 2'd1;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      slot_q <= SLOT_A;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign oSlot = slot_q;
  assign oLast = (slot_q == SLOT_D);

endmodule

// File: rtl/tdm_demux_one_to_four.sv
// Registered 1-to-4 TDM demultiplexer with frame-lock tracking and sync-error pulse.
module tdm_demux_one_to_four
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    iClk,
  input  logic                    iRst_n,
  tdm_demux_one_to_four_if.slave  bus
);

  state_e           state_d, state_q;
  logic [WIDTH-1:0] stg_a_d, stg_a_q;
  logic [WIDTH-1:0] stg_b_d, stg_b_q;
  logic [WIDTH-1:0] stg_c_d, stg_c_q;
  logic [WIDTH-1:0] ch_a_d, ch_a_q;
  logic [WIDTH-1:0] ch_b_d, ch_b_q;
  logic [WIDTH-1:0] ch_c_d, ch_c_q;
  logic [WIDTH-1:0] ch_d_d, ch_d_q;
  logic             fv_d, fv_q;
  logic             se_d, se_q;

  logic             cnt_clr, cnt_load1, cnt_inc;
  logic [1:0]       slot;
  logic             slot_last;

  tdm_slot_counter u_slot (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iClr   (cnt_clr),
    .iLoad1 (cnt_load1),
    .iInc   (cnt_inc),
    .oSlot  (slot),
    .oLast  (slot_last)
  );

  always_comb begin
    state_d   = state_q;
    stg_a_d   = stg_a_q;
    stg_b_d   = stg_b_q;
    stg_c_d   = stg_c_q;
    ch_a_d    = ch_a_q;
    ch_b_d    = ch_b_q;
    ch_c_d    = ch_c_q;
    ch_d_d    = ch_d_q;
    fv_d      = 1'b0;
    se_d      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;

    if (bus.iValid) begin
      unique case (state_q)
        HUNT: begin
          if (bus.iFrame) begin
            stg_a_d   = bus.iData;
            cnt_load1 = 1'b1;
            state_d   = LOCK;
          end
        end
        LOCK: begin
          if (bus.iFrame) begin
            // A marker anywhere but slot 0 restarts the frame on this sample.
            se_d      = (slot != SLOT_A);
            stg_a_d   = bus.iData;
            cnt_load1 = 1'b1;
          end else if (slot == SLOT_A) begin
            se_d    = 1'b1;
            cnt_clr = 1'b1;
            state_d = HUNT;
          end else if (slot_last) begin
            ch_a_d  = stg_a_q;
            ch_b_d  = stg_b_q;
            ch_c_d  = stg_c_q;
            ch_d_d  = bus.iData;
            fv_d    = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            if (slot == SLOT_B) begin
              stg_b_d = bus.iData;
            end else begin
              stg_c_d = bus.iData;
            end
            cnt_inc = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= HUNT;
      stg_a_q <= '0;
      stg_b_q <= '0;
      stg_c_q <= '0;
      ch_a_q  <= '0;
      ch_b_q  <= '0;
      ch_c_q  <= '0;
      ch_d_q  <= '0;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      stg_a_q <= stg_a_d;
      stg_b_q <= stg_b_d;
      stg_c_q <= stg_c_d;
      ch_a_q  <= ch_a_d;
      ch_b_q  <= ch_b_d;
      ch_c_q  <= ch_c_d;
      ch_d_q  <= ch_d_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
    end
  end

  assign bus.oChA        = ch_a_q;
  assign bus.oChB        = ch_b_q;
  assign bus.oChC        = ch_c_q;
  assign bus.oChD        = ch_d_q;
  assign bus.oFrameValid = fv_q;
  assign bus.oSyncErr    = se_q;
  assign bus.oLocked     = (state_q == LOCK);

endmodule

// File: tb/tb_tdm_demux_one_to_four.sv
// Directed-vector bench for the 1-to-4 TDM demultiplexer.
module tb_tdm_demux_one_to_four;

  logic iClk;
  logic iRst_n;
  int   total;
  int   bad;

  tdm_demux_one_to_four_if #(.WIDTH(8)) bus ();

  tdm_demux_one_to_four #(.WIDTH(8)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic f);
    @(negedge iClk);
    bus.iValid = 1'b1;
    bus.iData  = d;
    bus.iFrame = f;
  endtask

  task automatic idle();
    @(negedge iClk);
    bus.iValid = 1'b0;
    bus.iFrame = 1'b0;
    bus.iData  = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge iClk);
    bus.iValid = 1'b0;
    bus.iFrame = 1'b0;
    iRst_n = 1'b0;
    @(negedge iClk);
    iRst_n = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] exp);
    chk(tag, {bus.oChA, bus.oChB, bus.oChC, bus.oChD}, exp);
  endtask

  initial begin
    logic [7:0] fd;
    total = 0;
    bad   = 0;
    iRst_n = 1'b0;
    bus.iValid = 1'b0;
    bus.iFrame = 1'b0;
    bus.iData  = 8'h00;
    #12;
    do_reset();

    // Reset state
    chk("rst_locked", bus.oLocked, 0);
    chk("rst_fv", bus.oFrameValid, 0);
    chk("rst_se", bus.oSyncErr, 0);
    chk_out("rst_out", 32'h0);

    // Full-rate single frame
    send(8'h11, 1);
    chk("t1_unlocked_first", bus.oLocked, 0);
    send(8'h22, 0);
    chk("t1_locked", bus.oLocked, 1);
    send(8'h33, 0);
    send(8'h44, 0);
    chk("t1_fv_early", bus.oFrameValid, 0);
    idle();
    chk("t1_fv", bus.oFrameValid, 1);
    chk("t1_se", bus.oSyncErr, 0);
    chk_out("t1_out", 32'h11223344);
    idle();
    chk("t1_fv_once", bus.oFrameValid, 0);

    // Same frame with gaps, from a fresh reset
    do_reset();
    send(8'h11, 1); repeat (3) idle();
    send(8'h22, 0); repeat (3) idle();
    send(8'h33, 0); repeat (3) idle();
    chk_out("t2_hold_zero", 32'h0);
    send(8'h44, 0);
    idle();
    chk("t2_fv", bus.oFrameValid, 1);
    chk_out("t2_out", 32'h11223344);
    idle();
    chk("t2_fv_once", bus.oFrameValid, 0);

    // Early marker restarts the frame
    send(8'hAA, 1);
    send(8'hBB, 0);
    send(8'hCC, 1);
    chk("t3_se_pre", bus.oSyncErr, 0);
    send(8'hDD, 0);
    chk("t3_se", bus.oSyncErr, 1);
    chk("t3_locked", bus.oLocked, 1);
    chk_out("t3_hold", 32'h11223344);
    send(8'hEE, 0);
    chk("t3_se_clear", bus.oSyncErr, 0);
    send(8'hFF, 0);
    chk_out("t3_hold2", 32'h11223344);
    idle();
    chk("t3_fv", bus.oFrameValid, 1);
    chk_out("t3_out", 32'hCCDDEEFF);

    // Missing marker drops lock, then relock
    send(8'h55, 0);
    idle();
    chk("t4_se", bus.oSyncErr, 1);
    chk("t4_unlocked", bus.oLocked, 0);
    chk("t4_fv", bus.oFrameValid, 0);
    send(8'h66, 0);
    idle();
    chk("t4_ign_locked", bus.oLocked, 0);
    chk("t4_ign_se", bus.oSyncErr, 0);
    send(8'h01, 1);
    send(8'h02, 0);
    chk("t4_relock", bus.oLocked, 1);
    send(8'h03, 0);
    send(8'h04, 0);
    idle();
    chk("t4_fv2", bus.oFrameValid, 1);
    chk_out("t4_out", 32'h01020304);

    // Asynchronous reset mid-frame
    send(8'h77, 1);
    send(8'h88, 0);
    #2 iRst_n = 1'b0;
    #1;
    chk_out("t5_async_out", 32'h0);
    chk("t5_async_locked", bus.oLocked, 0);
    @(negedge iClk);
    iRst_n = 1'b1;
    send(8'h99, 0);
    send(8'h9A, 0);
    idle();
    chk_out("t5_out", 32'h0);
    chk("t5_locked", bus.oLocked, 0);
    chk("t5_fv", bus.oFrameValid, 0);

    // Three back-to-back frames at full rate
    for (int i = 0; i <= 12; i++) begin
      fd = {4'(i / 4 + 1), 4'(i % 4 + 1)};
      if (i < 12) send(fd, (i % 4) == 0);
      else idle();
      if (i > 0) begin
        chk($sformatf("t6_fv_%0d", i), bus.oFrameValid, (i % 4) == 0);
        chk($sformatf("t6_se_%0d", i), bus.oSyncErr, 0);
        if ((i % 4) == 0) begin
          fd = 8'(i / 4);
          chk_out($sformatf("t6_out_%0d", i),
                  {fd[3:0], 4'h1, fd[3:0], 4'h2, fd[3:0], 4'h3, fd[3:0], 4'h4});
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux_one_to_four.md
# tdm_demux_one_to_four

Registered 1-to-4 time-division demultiplexer: accepts a serial sample stream in which four channels are interleaved A, B, C, D, with a frame marker on channel A. It reassembles each complete frame into four parallel channel outputs. It sits on the receive side of the team's 4-to-1 channel multiplexer path and undoes the interleave that a mux-based TDM sender produces. The block provides frame-lock tracking and an error pulse for misaligned frames.

## Interface
- WIDTH, 8, sample width in bits (≥1)
- iClk  input  1  clock, all logic on rising edge
- iRst_n  input  1  asynchronous, active-low reset
- iData  input  WIDTH  serial sample, qualified by iValid
- iValid  input  1  sample present this cycle; no backpressure, gaps of any length allowed
- iFrame  input  1  marks the current valid sample as slot 0 (channel A); ignored when iValid=0
- oChA, oChB, oChC, oChD  output  WIDTH each  last complete frame, held until next frame completes
- oFrameValid  output  1  one-cycle pulse: oChA..oChD just updated
- oSyncErr  output  1  one-cycle pulse: frame alignment violated
- oLocked  output  1  high while in LOCK state

## Operation
- States: HUNT, LOCK. 2-bit slot counter `slot` (0..3) and three WIDTH staging registers for A, B and C.
- Sample event = iValid high on a rising edge. Cycles with iValid=0 change nothing except clearing the pulses.
- HUNT:
  - Sample without iFrame: discarded.
  - Sample with iFrame: stage as A, slot←1, go to LOCK.
- LOCK, on a sample event:
  - slot=0 and iFrame=1: stage A, slot←1.
  - slot=0 and iFrame=0: missing marker. Pulse oSyncErr, discard the sample, go to HUNT.
  - slot∈{1,2,3} and iFrame=1: early marker. Pulse oSyncErr, drop the partial frame, stage this sample as A, slot←1, stay in LOCK.
  - slot∈{1,2} and iFrame=0: stage B or C, slot←slot+1.
  - slot=3 and iFrame=0: load oChA..oChC from staging and oChD←iData. Pulse oFrameValid, slot←0.
- A dropped partial frame never reaches the outputs. The outputs only ever change as a complete set of four.
- oFrameValid and oSyncErr are never high in the same cycle. The transitions above make them mutually exclusive.
- The slot counter wraps 3→0 only on frame completion. It is never incremented in HUNT.

## Timing
- Reset (iRst_n low, asynchronous): state←HUNT, slot←0, staging←0, oChA..oChD←0, oFrameValid←0, oSyncErr←0, oLocked←0.
- Reset deassertion is used synchronously: the first sample can be accepted on the first rising edge with iRst_n high.
- Reset mid-frame discards all partial data. A frame in progress never completes after reset.
- Latency: oChA..oChD and oFrameValid are registered. They update on the same edge that accepts the slot-3 sample, so they are visible the cycle after that sample is presented.
- oSyncErr is registered and visible the cycle after the offending sample.
- oLocked follows the registered state. It is high the cycle after the marker sample is accepted in HUNT, and it drops the cycle after a missing-marker error.
- Maximum throughput is one sample per cycle, which gives a back-to-back oFrameValid every 4 cycles.

## Structure
- Shared package tdm_pkg holds:
  - state enum {HUNT, LOCK};
  - slot constants SLOT_A=0, SLOT_B=1, SLOT_C=2, SLOT_D=3;
  - NUM_CH=4.
- One natural sub-module: tdm_slot_counter.
  - 2-bit counter with load-to-1, increment and clear inputs.
  - Exposes slot and last (slot==3).
  - Instantiated once.
- Everything else (FSM, staging and output registers) lives in the top module.

## Test plan
- Reset, then with iValid=1 continuously send iFrame=1 with 0x11, then 0x22, 0x33, 0x44 → oLocked=1 from cycle 2; oFrameValid pulses once; oChA..D=0x11,0x22,0x33,0x44; oSyncErr stays 0.
- Same frame with iValid low for 3 cycles between every sample → identical outputs, with oFrameValid one cycle after the 0x44 sample.
- Locked: send 0xAA (iFrame=1), 0xBB, then 0xCC with iFrame=1, then 0xDD, 0xEE, 0xFF → oSyncErr pulses after 0xCC; the next oFrameValid gives 0xCC,0xDD,0xEE,0xFF; the previous outputs hold until then.
- After one good frame, send 0x55 with iFrame=0 at slot 0 → oSyncErr pulses and oLocked drops. Then 0x66 (iFrame=0) → ignored. Then 0x01 (iFrame=1), 0x02, 0x03, 0x04 → relock and output 0x01..0x04.
- Assert iRst_n low after two samples of a frame, release, then send two more samples without iFrame → all outputs 0, oLocked=0, no oFrameValid.
- Send 3 back-to-back frames at full rate → oFrameValid high every 4th cycle, each output set matches its frame.
